// File: rtl/switch_press_counter.sv
// switch_press_counter
// Front end of the two-digit seven-segment display path. Two raw push-switches
// are synchronised and debounced; each release of the increment switch advances
// a two-digit counter (BCD 00..99 or hex 00..FF), and each press of the clear
// switch returns it to 00. Every output comes straight from a flop.

module switch_press_counter #(
    parameter int DEBOUNCE_LIMIT = 250000,
    parameter bit BCD_MODE       = 1'b1
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_switch_inc,
    input  logic       i_switch_clr,
    output logic [3:0] o_digit_hi,
    output logic [3:0] o_digit_lo,
    output logic       o_wrap
);

    // Counter just wide enough to hold DEBOUNCE_LIMIT itself.
    localparam int CNT_W = $clog2(DEBOUNCE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(DEBOUNCE_LIMIT);

    // Bit positions of the two switches in the per-switch vectors below.
    localparam int SW_INC = 0;
    localparam int SW_CLR = 1;

    logic [1:0]       raw;
    logic [1:0]       sync1;
    logic [1:0]       sync2;
    logic [1:0]       stable;
    logic [1:0]       prev;
    logic [CNT_W-1:0] deb_cnt [2];

    logic inc_event;
    logic clr_event;

    assign raw = {i_switch_clr, i_switch_inc};

    // Two-flop synchroniser per switch; nothing downstream looks at raw.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            // NOTE: non-blocking here so sync2 takes the previous sync1,
            // giving two real flop stages instead of one collapsed wire.
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Per-switch debounce: stable follows sync2 only after it has differed
    // for DEBOUNCE_LIMIT consecutive edges; any agreeing edge restarts the run.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            // NOTE: this two-entry array is plain control state, so every
            // entry is reset; a mid-debounce run must not survive reset.
            for (int i = 0; i < 2; i++) begin
                deb_cnt[i] <= '0;
            end
            stable <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == stable[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] + CNT_ONE == CNT_LIMIT) begin
                    stable[i]  <= sync2[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + CNT_ONE;
                end
            end
        end
    end

    // Previous debounced level, for edge detection.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            prev <= '0;
        end else begin
            prev <= stable;
        end
    end

    // Count on release of inc (so a held switch counts once), clear on press.
    assign inc_event = prev[SW_INC] & ~stable[SW_INC];
    assign clr_event = ~prev[SW_CLR] & stable[SW_CLR];

    // Digit counter and single-cycle wrap pulse; clear beats increment.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_digit_hi <= '0;
            o_digit_lo <= '0;
            o_wrap     <= 1'b0;
        end else begin
            // NOTE: o_wrap gets a default on every edge, so only the wrapping
            // branch below raises it and it can never stay high twice.
            o_wrap <= 1'b0;
            if (clr_event) begin
                o_digit_hi <= '0;
                o_digit_lo <= '0;
            end else if (inc_event) begin
                if (BCD_MODE) begin
                    if (o_digit_lo != 4'd9) begin
                        o_digit_lo <= o_digit_lo + 4'd1;
                    end else begin
                        o_digit_lo <= '0;
                        if (o_digit_hi != 4'd9) begin
                            o_digit_hi <= o_digit_hi + 4'd1;
                        end else begin
                            o_digit_hi <= '0;
                            o_wrap     <= 1'b1;
                        end
                    end
                end else begin
                    {o_digit_hi, o_digit_lo} <= {o_digit_hi, o_digit_lo} + 8'd1;
                    o_wrap <= (o_digit_hi == 4'hF) && (o_digit_lo == 4'hF);
                end
            end
        end
    end

endmodule

// File: doc/switch_press_counter.md
Name: switch_press_counter

Overview:
- Upstream stage of the two-digit seven-segment display path.
- Synchronises and debounces two push-switches, then counts release events of the increment switch.
- Presents the count as two 4-bit digit nibbles, each feeding one seven-segment decoder instance.
- Counts in decimal (BCD, 00..99) or hex (00..FF), selected by parameter; emits a one-cycle wrap pulse.

Parameters:
DEBOUNCE_LIMIT, 250000, consecutive clock cycles a synchronised input must differ from its stable state before the stable state flips (10 ms at 25 MHz); legal range >= 1.
BCD_MODE, 1, 1 = decimal digits 0..9 per nibble, wrap 99->00; 0 = hex digits 0..F, wrap FF->00.

Ports:
i_clk  input  1  system clock; all state updates on rising edge.
i_rst_n  input  1  asynchronous, active-low reset.
i_switch_inc  input  1  raw increment switch, asynchronous to i_clk, 1 = pressed.
i_switch_clr  input  1  raw clear switch, asynchronous to i_clk, 1 = pressed.
o_digit_hi  output  4  upper digit (tens in BCD mode, high nibble in hex mode).
o_digit_lo  output  4  lower digit (units in BCD mode, low nibble in hex mode).
o_wrap  output  1  one-cycle pulse on the edge where the count wraps to 00.

Behaviour:
- Reset (i_rst_n = 0, asynchronous assert): every register goes to 0 immediately. This covers sync flops, debounce counters, stable states, previous-stable registers, o_digit_hi, o_digit_lo and o_wrap.
- Reset release is synchronous to i_clk by use; the block does not re-synchronise deassertion internally.
- Synchroniser: each switch passes through two flops (sync1, sync2) before any other logic sees it.
- Debounce, per switch, independently:
  - Counter width is clog2(DEBOUNCE_LIMIT+1).
  - Each edge where sync2 != stable: counter increments.
  - When the counter reaches DEBOUNCE_LIMIT on that edge: stable <= sync2 and counter <= 0.
  - Any edge where sync2 == stable: counter <= 0.
  - A glitch shorter than DEBOUNCE_LIMIT consecutive cycles never changes stable.
- Edge detect: prev register takes stable every edge.
  - inc_event = prev_inc & ~stable_inc (release of the increment switch).
  - clr_event = ~prev_clr & stable_clr (press of the clear switch).
- Count update, on the edge following the event condition:
  - clr_event: both digits <= 0, o_wrap <= 0. Clear takes priority over a simultaneous inc_event, which is discarded.
  - inc_event, BCD mode:
    - If lo < 9: lo += 1.
    - If lo == 9: lo <= 0 and hi += 1.
    - If hi == 9 and lo == 9: both digits <= 0 and o_wrap <= 1.
  - inc_event, hex mode: {hi,lo} += 1 modulo 256; o_wrap <= 1 only on the FF->00 transition.
  - Otherwise: digits hold and o_wrap <= 0. o_wrap is never high for two consecutive cycles from a single event.
- Latency: take edge 0 as the first rising edge that samples the new raw level.
  - Stable flips on edge DEBOUNCE_LIMIT+1.
  - The count/o_wrap change is visible after edge DEBOUNCE_LIMIT+2.
- Outputs are fully registered, with no combinational path from inputs.
- BCD digits never exceed 9 by construction.
- Reset mid-debounce: the partial count is lost.
- Switch held through reset release: stable rises after debounce, but no increment occurs until release. A held clear switch produces one clear event (harmless, count already 0).
- Holding inc pressed indefinitely produces exactly one increment, on release.

Test Plan:
(DEBOUNCE_LIMIT=4, BCD_MODE=1 unless noted)
1. Reset then idle 20 cycles -> o_digit_hi=0, o_digit_lo=0, o_wrap=0 throughout.
2. Press inc 10 cycles, release -> no change on press; digits become 0/1 exactly 6 edges after the first edge sampling release; o_wrap stays 0.
3. Inc pulses of 1, 2 and 3 cycles, each separated by 10 low cycles -> digits unchanged.
4. 99 clean press/release pairs -> hi=9, lo=9. One more -> digits 0/0 with o_wrap high for exactly one cycle on the same edge.
5. Count at 0/7, press clr -> digits 0/0 six edges after the first edge sampling the press, o_wrap=0. Releasing clr causes no change.
6. BCD_MODE=0: preset to 0/F via 15 presses, one more -> 1/0. Continue to F/F, one more -> 0/0 with a single-cycle o_wrap. Also: assert i_rst_n=0 mid-debounce -> all outputs 0 immediately, and no increment results after reset release.
